// File: rtl/mnist_infer_sequencer_pkg.sv
// mnist_seq_pkg: shared states, transfer geometry and fp32 ordering key for the inference sequencer.
package mnist_seq_pkg;
  localparam logic [25:0] IMG_BASE = 26'h0000000;
  localparam logic [25:0] WEIGHT_BASE = 26'h0010000;
  localparam int IMG_BEATS = 49;
  localparam int WEIGHT_BEATS = 196;
  localparam int NUM_CLASSES = 10;
  localparam logic [25:0] ROW_BYTES = 26'(WEIGHT_BEATS * 16);
  typedef enum logic [2:0] {IDLE, IMG_RD, IMG_GAP, NEU_START, W_RD, W_GAP, MAC_WAIT, FINISH} state_t;
  // Maps fp32 bit patterns onto an unsigned total order (+0 above -0, NaN by bits).
  function automatic logic [31:0] fp32_order_key(input logic [31:0] b);
    return b[31] ? ~b : (b | 32'h80000000);
  endfunction
endpackage

// File: rtl/mnist_infer_sequencer_argmax.sv
// fp32_argmax_tracker: keeps the index/value of the largest fp32 seen since clear; first valid loads unconditionally.
module fp32_argmax_tracker
  import mnist_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        valid,
  input  logic [31:0] value,
  input  logic [3:0]  index,
  output logic [3:0]  best_index,
  output logic [31:0] best_value
);
  logic has_q, has_d, take;
  logic [3:0] idx_q, idx_d;
  logic [31:0] val_q, val_d;
  always_comb begin
    take = valid && (!has_q || fp32_order_key(value) > fp32_order_key(val_q));
    has_d = !clear && (has_q || valid);
    idx_d = clear ? '0 : take ? index : idx_q;
    val_d = clear ? '0 : take ? value : val_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      has_q <= 1'b0;
      idx_q <= '0;
      val_q <= '0;
    end else begin
      has_q <= has_d;
      idx_q <= idx_d;
      val_q <= val_d;
    end
  end
  assign best_index = idx_q;
  assign best_value = val_q;
endmodule

// File: rtl/mnist_infer_sequencer.sv
// mnist_infer_sequencer: fetches the image and ten weight rows over the bridge, feeds fp_mac and reports the argmax class.
module mnist_infer_sequencer
  import mnist_seq_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [3:0]   result_index,
  output logic [31:0]  result_value,
  output logic [25:0]  interface_address,
  output logic [15:0]  interface_byte_enable,
  output logic         interface_read,
  input  logic         interface_acknowledge,
  input  logic [127:0] interface_read_data,
  output logic         img_wr_en,
  output logic [9:0]   img_wr_addr,
  output logic [127:0] img_wr_data,
  output logic         mac_start,
  output logic         mac_data_valid,
  output logic [127:0] mac_data,
  input  logic         mac_done,
  input  logic [31:0]  mac_result
);
  state_t state_q, state_d;
  logic [25:0] addr_q, addr_d, row_q, row_d;
  logic [7:0] beat_q, beat_d;
  logic [3:0] neuron_q, neuron_d;
  logic img_wr_en_q, img_wr_en_d, mac_dv_q, mac_dv_d;
  logic [9:0] wr_addr_q, wr_addr_d;
  logic [127:0] data_q, data_d;
  logic ack, clear;
  assign interface_read = state_q == IMG_RD || state_q == W_RD;
  assign ack = interface_read && interface_acknowledge;
  always_comb begin
    state_d = state_q;
    addr_d = ack ? addr_q + 26'd16 : addr_q;
    row_d = row_q;
    beat_d = ack ? beat_q + 8'd1 : beat_q;
    neuron_d = neuron_q;
    wr_addr_d = ack ? {beat_q[5:0], 4'b0} : wr_addr_q;
    data_d = ack ? interface_read_data : data_q;
    img_wr_en_d = ack && state_q == IMG_RD;
    mac_dv_d = ack && state_q == W_RD;
    clear = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = IMG_RD;
        addr_d = IMG_BASE;
        row_d = WEIGHT_BASE;
        beat_d = '0;
        neuron_d = '0;
        clear = 1'b1;
      end
      IMG_RD: if (ack) state_d = beat_q == 8'(IMG_BEATS - 1) ? NEU_START : IMG_GAP;
      IMG_GAP: state_d = IMG_RD;
      // Row base advances by a constant stride instead of multiplying by the neuron index.
      NEU_START: begin
        state_d = W_RD;
        addr_d = row_q;
        row_d = row_q + ROW_BYTES;
        beat_d = '0;
      end
      W_RD: if (ack) state_d = beat_q == 8'(WEIGHT_BEATS - 1) ? MAC_WAIT : W_GAP;
      W_GAP: state_d = W_RD;
      MAC_WAIT: if (mac_done) begin
        state_d = neuron_q == 4'(NUM_CLASSES - 1) ? FINISH : NEU_START;
        neuron_d = neuron_q + 4'd1;
      end
      FINISH: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      row_q <= '0;
      beat_q <= '0;
      neuron_q <= '0;
      wr_addr_q <= '0;
      data_q <= '0;
      img_wr_en_q <= 1'b0;
      mac_dv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      row_q <= row_d;
      beat_q <= beat_d;
      neuron_q <= neuron_d;
      wr_addr_q <= wr_addr_d;
      data_q <= data_d;
      img_wr_en_q <= img_wr_en_d;
      mac_dv_q <= mac_dv_d;
    end
  end
  fp32_argmax_tracker u_argmax (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .valid      (state_q == MAC_WAIT && mac_done),
    .value      (mac_result),
    .index      (neuron_q),
    .best_index (result_index),
    .best_value (result_value)
  );
  assign busy = state_q != IDLE && state_q != FINISH;
  assign done = state_q == FINISH;
  assign mac_start = state_q == NEU_START;
  assign interface_address = addr_q;
  assign interface_byte_enable = 16'hFFFF;
  assign img_wr_en = img_wr_en_q;
  assign img_wr_addr = wr_addr_q;
  assign img_wr_data = data_q;
  assign mac_data_valid = mac_dv_q;
  assign mac_data = data_q;
endmodule

// File: tb/tb_mnist_infer_sequencer.sv
// tb_mnist_infer_sequencer: bridge/MAC responders with random ack delays and data, checked against a sign-magnitude argmax model.
module tb_mnist_infer_sequencer;
  localparam logic [25:0] WB = 26'h0010000;
  logic clk = 0, reset_n = 0, start = 0, ack = 0, mac_done = 0;
  logic [127:0] rdata = '0;
  logic [31:0] mac_result = '0;
  logic busy, done, interface_read, img_wr_en, mac_start, mac_data_valid;
  logic [3:0] result_index;
  logic [31:0] result_value;
  logic [25:0] interface_address;
  logic [15:0] interface_byte_enable;
  logic [9:0] img_wr_addr;
  logic [127:0] img_wr_data, mac_data;

  mnist_infer_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .result_index(result_index), .result_value(result_value),
    .interface_address(interface_address), .interface_byte_enable(interface_byte_enable),
    .interface_read(interface_read), .interface_acknowledge(ack), .interface_read_data(rdata),
    .img_wr_en(img_wr_en), .img_wr_addr(img_wr_addr), .img_wr_data(img_wr_data),
    .mac_start(mac_start), .mac_data_valid(mac_data_valid), .mac_data(mac_data),
    .mac_done(mac_done), .mac_result(mac_result)
  );

  always #10 clk = ~clk;

  int checks = 0, failures = 0;
  int maxd = 0, mdelay = 5;
  bit abuse = 0, hold = 0;
  logic [31:0] salt = '0;
  logic [31:0] res [10];
  int starts, done_n, stab_err, seq_err, lat_err, acks, row_cnt, md_cnt, dly;
  bit pending, spur_mac, spur_ack, trig;
  logic [25:0] lat_addr, wmin, wmax;
  logic [127:0] img_q[$], mac_q[$];
  logic [9:0] imgaddr_q[$];
  logic [3:0] got_idx;
  logic [31:0] got_val;

  function automatic logic [127:0] mem(input logic [25:0] a, input logic [31:0] s);
    logic [31:0] x;
    x = {6'h0, a};
    return {(x * 32'h01000193) ^ s, ~x ^ {s[15:0], s[31:16]}, x + s, {x[7:0], x[31:8]} ^ 32'h5a5a5a5a};
  endfunction

  function automatic bit gt(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return !a[31];
    if (!a[31]) return a[30:0] > b[30:0];
    return a[30:0] < b[30:0];
  endfunction

  function automatic int ref_argmax();
    int b = 0;
    for (int i = 1; i < 10; i++) if (gt(res[i], res[b])) b = i;
    return b;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Bridge slave, fp_mac stand-in and output monitor, all acting on the falling edge.
  initial forever begin
    @(negedge clk);
    ack = 0;
    mac_done = 0;
    if (!reset_n) begin
      pending = 0;
      md_cnt = 0;
      trig = 0;
    end else begin
      if (mac_start || done) begin
        if (!trig) lat_err++;
      end else if (trig) lat_err++;
      trig = 0;
      if (start && !busy) begin
        img_q.delete(); mac_q.delete(); imgaddr_q.delete();
        starts = 0; done_n = 0; stab_err = 0; seq_err = 0; lat_err = 0; acks = 0;
        row_cnt = 0; md_cnt = 0; spur_mac = 0; spur_ack = 0; wmin = '1; wmax = '0;
      end
      if (img_wr_en) begin
        img_q.push_back(img_wr_data);
        imgaddr_q.push_back(img_wr_addr);
      end
      if (mac_start) begin
        if (starts > 0 && row_cnt != 196) seq_err++;
        starts++;
        row_cnt = 0;
      end
      if (md_cnt > 0) begin
        md_cnt--;
        if (md_cnt == 0) begin
          mac_done = 1;
          mac_result = res[starts-1];
          trig = 1;
        end
      end
      if (mac_data_valid) begin
        mac_q.push_back(mac_data);
        row_cnt++;
        if (row_cnt == 196) md_cnt = mdelay;
      end
      if (done) begin
        done_n++;
        if (row_cnt != 196) seq_err++;
        got_idx = result_index;
        got_val = result_value;
      end
      if (abuse && !spur_mac && starts == 3 && row_cnt == 10 && interface_read) begin
        mac_done = 1;
        mac_result = 32'h7f7fffff;
        spur_mac = 1;
      end
      if (pending && (!interface_read || interface_address != lat_addr)) stab_err++;
      if (!pending && interface_read) begin
        pending = 1;
        lat_addr = interface_address;
        dly = hold ? 1 << 30 : $urandom_range(0, maxd);
      end
      if (pending) begin
        if (dly == 0) begin
          ack = 1;
          rdata = mem(lat_addr, salt);
          pending = 0;
          acks++;
          if (lat_addr >= WB && lat_addr < wmin) wmin = lat_addr;
          if (lat_addr >= WB && lat_addr > wmax) wmax = lat_addr;
          if (lat_addr == 26'd768) trig = 1;
        end else dly--;
      end else if (abuse && !spur_ack && img_q.size() == 5 && !interface_read) begin
        ack = 1;
        rdata = '1;
        spur_ack = 1;
      end
    end
  end

  task automatic do_run(input string nm, input int md, input bit ab);
    int err = 0;
    int e;
    maxd = md;
    abuse = ab;
    hold = 0;
    salt = $urandom;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    for (int i = 0; i < 60000 && done_n == 0; i++) begin
      @(posedge clk); #1 start = ab && i == 200;
    end
    start = 0;
    repeat (4) @(posedge clk);
    #1;
    check({nm, ":done_once"}, 128'(done_n), 128'd1);
    check({nm, ":busy_after"}, 128'(busy), 128'd0);
    check({nm, ":img_writes"}, 128'(img_q.size()), 128'd49);
    check({nm, ":mac_starts"}, 128'(starts), 128'd10);
    check({nm, ":mac_beats"}, 128'(mac_q.size()), 128'd1960);
    check({nm, ":acks"}, 128'(acks), 128'd2009);
    check({nm, ":stable"}, 128'(stab_err), 128'd0);
    check({nm, ":row_seq"}, 128'(seq_err), 128'd0);
    check({nm, ":latency"}, 128'(lat_err), 128'd0);
    check({nm, ":wmin"}, 128'(wmin), 128'(WB));
    check({nm, ":wmax"}, 128'(wmax), 128'(WB + 26'd31344));
    for (int k = 0; k < img_q.size(); k++)
      if (imgaddr_q[k] !== 10'(k * 16) || img_q[k] !== mem(26'(k * 16), salt)) err++;
    for (int j = 0; j < mac_q.size(); j++)
      if (mac_q[j] !== mem(WB + 26'(j * 16), salt)) err++;
    check({nm, ":data_order"}, 128'(err), 128'd0);
    e = ref_argmax();
    check({nm, ":result_index"}, 128'(got_idx), 128'(e));
    check({nm, ":result_value"}, 128'(got_val), 128'(res[e]));
  endtask

  initial begin
    #15;
    check("rst:busy", 128'(busy), 128'd0);
    check("rst:done", 128'(done), 128'd0);
    check("rst:read", 128'(interface_read), 128'd0);
    check("rst:addr", 128'(interface_address), 128'd0);
    check("rst:be", 128'(interface_byte_enable), 128'hFFFF);
    check("rst:img_wr_en", 128'(img_wr_en), 128'd0);
    check("rst:mac_start", 128'(mac_start), 128'd0);
    check("rst:mac_dv", 128'(mac_data_valid), 128'd0);
    check("rst:result", 128'({result_index, result_value}), 128'd0);
    @(posedge clk); #1 reset_n = 1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 10; i++) res[i] = $urandom;
    do_run("zero_wait", 0, 0);
    for (int i = 0; i < 10; i++) res[i] = $urandom;
    do_run("rand_wait", 20, 0);

    res = '{32'h3f800000, 32'h40400000, 32'hc0000000, 32'h40400000, 32'h3f000000,
            32'h40000000, 32'h3fc00000, 32'h00000000, 32'hbf800000, 32'h40200000};
    do_run("tie", 3, 0);
    check("tie:index1", 128'(got_idx), 128'd1);
    check("tie:value3p0", 128'(got_val), 128'h40400000);

    res = '{32'hc0a00000, 32'hc0800000, 32'hc0400000, 32'hc0000000, 32'hc0a00000,
            32'hc0800000, 32'hc0400000, 32'hbf800000, 32'hc0000000, 32'hc0400000};
    do_run("neg", 0, 0);
    check("neg:index7", 128'(got_idx), 128'd7);

    res = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h00000000,
            32'h80000000, 32'h00000000, 32'h80000000, 32'h80000000, 32'h80000000};
    do_run("signed_zero", 0, 0);
    check("signed_zero:index4", 128'(got_idx), 128'd4);
    check("signed_zero:value", 128'(got_val), 128'd0);

    for (int i = 0; i < 10; i++) res[i] = $urandom;
    do_run("abuse", 0, 1);

    hold = 1;
    abuse = 0;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    for (int i = 0; i < 50 && !interface_read; i++) @(posedge clk);
    check("rst_mid:read_before", 128'(interface_read), 128'd1);
    repeat (3) @(posedge clk);
    @(negedge clk); #2 reset_n = 0;
    #1;
    check("rst_mid:read_drop", 128'(interface_read), 128'd0);
    check("rst_mid:busy_drop", 128'(busy), 128'd0);
    hold = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 10; i++) res[i] = $urandom;
    do_run("post_reset", 5, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mnist_infer_sequencer.md
Name: mnist_infer_sequencer

Overview:
- Sequences one MNIST inference over the shared 128-bit external-bridge read port.
- Fetches a 784-byte image from SDRAM into the image buffer, then fetches each class's fp32 weight row and streams it to fp_mac.
- Collects each MAC result and reports the argmax class index.
- Replaces the ad-hoc state/address logic at the top level; owns the bridge read master while busy.

Parameters:
INTERFACE_WIDTH_BITS, 128, bridge data width
INTERFACE_ADDR_BITS, 26, bridge byte-address width
IMG_BASE, 26'h0000000, byte address of image
WEIGHT_BASE, 26'h0010000, byte address of class-0 weight row
IMG_BEATS, 49, 128-bit beats per image (784/16)
WEIGHT_BEATS, 196, beats per weight row (784 fp32 / 4)
NUM_CLASSES, 10, neurons evaluated

Ports:
clk  in  1  system clock (50 MHz)
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin inference
busy  out  1  high from accepted start until done
done  out  1  one-cycle completion pulse
result_index  out  4  argmax class, valid from done until next start
result_value  out  32  fp32 winning MAC result
interface_address  out  26  bridge byte address
interface_byte_enable  out  16  bridge byte enables
interface_read  out  1  bridge read request
interface_acknowledge  in  1  bridge ack; read data valid this cycle
interface_read_data  in  128  bridge read data
img_wr_en  out  1  image-buffer beat write strobe
img_wr_addr  out  10  byte index of beat's byte 0 (0,16,...,768)
img_wr_data  out  128  16 image bytes, byte 0 in [7:0]
mac_start  out  1  one-cycle pulse: clear accumulator, begin row
mac_data_valid  out  1  weight beat valid strobe
mac_data  out  128  four fp32 weights, weight 0 in [31:0]
mac_done  in  1  row accumulation complete
mac_result  in  32  fp32 row result, valid with mac_done

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0, except interface_byte_enable = 16'hFFFF constant. Reset mid-transfer drops interface_read immediately; the in-flight read is abandoned.
- Bridge rule: one outstanding read. interface_read and interface_address held stable until ack sampled high. On the ack cycle, data is captured and read deasserts the next cycle. Minimum one idle cycle between reads. Ack while read low is ignored.
- States:
  - IDLE: start -> IMG_RD; busy=1; addr=IMG_BASE; beat=0. start while busy is ignored.
  - IMG_RD: read=1. On ack:
    - Register img_wr_en=1 next cycle with img_wr_addr=beat*16 and img_wr_data=read_data.
    - addr += 16.
    - If beat==IMG_BEATS-1 -> NEU_START, else beat++ -> IMG_GAP.
  - IMG_GAP: 1 cycle -> IMG_RD.
  - NEU_START: mac_start=1 for 1 cycle; addr=WEIGHT_BASE+neuron*WEIGHT_BEATS*16 via running register, no multiplier; beat=0 -> W_RD.
  - W_RD: read=1. On ack:
    - mac_data_valid=1 with mac_data=read_data next cycle.
    - addr += 16.
    - If last beat -> MAC_WAIT, else W_GAP.
  - W_GAP: 1 cycle -> W_RD.
  - MAC_WAIT: on mac_done, update argmax; if neuron==NUM_CLASSES-1 -> FINISH, else neuron++ -> NEU_START. mac_done in any other state is ignored.
  - FINISH: done=1 for 1 cycle; busy=0 -> IDLE.
- Argmax:
  - Key = sign ? ~bits : bits|32'h80000000, compared unsigned.
  - Neuron 0 is loaded unconditionally.
  - Later neurons replace the current best only if strictly greater; ties keep the lower index. +0 beats -0. NaN is ordered by bit pattern, with no special handling.
- Latency: image read done to first mac_start = 1 cycle; mac_done to next mac_start = 1 cycle; last mac_done to done = 1 cycle.
- Address wrap: addition is modulo 2^26, with no error.

Decomposition:
- Package mnist_seq_pkg: state enum, beat/class constants, fp32_order_key function.
- Sub-module fp32_argmax_tracker (clear, valid, value, index -> best_index, best_value).

Test Plan:
- Zero-wait ack on every read, mac_done 5 cycles after the last beat:
  - 49 img_wr_en strobes at addresses 0..768 step 16.
  - 10 mac_start pulses, each followed by 196 mac_data_valid strobes.
  - Addresses span WEIGHT_BASE..+31359.
  - done exactly once.
- Random ack delays 0-20 cycles: address/read stable while waiting; exactly one ack consumed per beat; data ordering preserved.
- mac_result sequence 1.0, 3.0, -2.0, 3.0, 0.5 ... with class 1 max: result_index=1, result_value=32'h40400000 (tie with class 3 keeps 1).
- All results negative (-5.0 ... -1.0 at class 7): result_index=7. +0 vs -0 only: +0 index wins.
- start asserted during busy plus spurious mac_done during W_RD: no restart, no state change.
- reset_n low while IMG_RD is waiting on ack: interface_read falls asynchronously; after release a new start performs a full clean run.
